// File: rtl/vcve2_vrf_agu.sv
// VRF address generator: per-operand word address sequencing for vs1/vs2/vd register groups.
// Optional group-alignment check enabled by defining VCVE2_AGU_GROUP_CHECK_EN.
module vcve2_vrf_agu #(
    parameter int unsigned VLEN      = 128,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [4:0]  vs1_i,
    input  logic [4:0]  vs2_i,
    input  logic [4:0]  vd_i,
    input  logic [2:0]  lmul_i,
    input  logic        get_rs1_i,
    input  logic        get_rs2_i,
    input  logic        get_rd_i,
    output logic        ready_o,
    output logic [31:0] addr_o,
    output logic        addr_valid_o,
    output logic        last_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned WPR  = VLEN / 32;
    localparam int unsigned OFFW = $clog2(VLEN * 4);
    localparam int unsigned SH   = $clog2(VLEN / 8);
    localparam int unsigned CW   = $clog2(VLEN / 4) + 1;

    typedef enum logic [1:0] {IDLE, INIT, READY} state_e;

    state_e          state_q, state_d;
    logic [4:0]      idx_q [3];
    logic [CW-1:0]   cnt_q [3];
    logic [OFFW-1:0] off_q [3];
    logic [CW-1:0]   n_q, n_load;
    logic [1:0]      sel;
    logic            served, last_hit, bad_load, done_q;

    // Offsets live in a power-of-two field spanning the whole VRF, so +4 wraps naturally.
    function automatic logic [OFFW-1:0] start_off(input logic [4:0] idx);
        return OFFW'(idx) << SH;
    endfunction

    always_comb begin
        unique case (lmul_i)
            3'b001:  n_load = CW'(WPR << 1);
            3'b010:  n_load = CW'(WPR << 2);
            3'b011:  n_load = CW'(WPR << 3);
            3'b101:  n_load = CW'(WPR >> 3);
            3'b110:  n_load = CW'(WPR >> 2);
            3'b111:  n_load = CW'(WPR >> 1);
            default: n_load = CW'(WPR);
        endcase
        if (n_load == '0) n_load = CW'(1);
    end

`ifdef VCVE2_AGU_GROUP_CHECK_EN
    logic [2:0] align_mask;
    logic       err_q;

    always_comb begin
        unique case (lmul_i)
            3'b001:  align_mask = 3'b001;
            3'b010:  align_mask = 3'b011;
            3'b011:  align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
        bad_load = |((vs1_i[2:0] | vs2_i[2:0] | vd_i[2:0]) & align_mask);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= load_i && bad_load;
    end

    assign err_o = err_q;
`else
    assign bad_load = 1'b0;
    assign err_o    = 1'b0;
`endif

    always_comb begin
        sel = 2'd2;
        if (get_rs1_i)      sel = 2'd0;
        else if (get_rs2_i) sel = 2'd1;
    end

    assign served   = (state_q == READY) && (get_rs1_i || get_rs2_i || get_rd_i);
    assign last_hit = cnt_q[sel] == (n_q - CW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ready_o      = 1'b0;
        addr_valid_o = 1'b0;
        addr_o       = '0;
        last_o       = 1'b0;
        unique case (state_q)
            INIT: state_d = READY;
            READY: begin
                ready_o = 1'b1;
                if (served) begin
                    addr_valid_o = 1'b1;
                    addr_o       = BASE_ADDR + 32'(off_q[sel]);
                    last_o       = last_hit;
                    if (sel == 2'd2 && last_hit) state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (load_i) state_d = bad_load ? IDLE : INIT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 3; i++) begin
                idx_q[i] <= '0;
                cnt_q[i] <= '0;
                off_q[i] <= '0;
            end
            n_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= served && (sel == 2'd2) && last_hit && !load_i;
            if (load_i) begin
                idx_q[0] <= vs1_i;
                idx_q[1] <= vs2_i;
                idx_q[2] <= vd_i;
                n_q      <= n_load;
                for (int unsigned i = 0; i < 3; i++) begin
                    cnt_q[i] <= '0;
                    off_q[i] <= '0;
                end
            end else if (state_q == INIT) begin
                for (int unsigned i = 0; i < 3; i++) off_q[i] <= start_off(idx_q[i]);
            end else if (served) begin
                if (last_hit) begin
                    cnt_q[sel] <= '0;
                    off_q[sel] <= start_off(idx_q[sel]);
                end else begin
                    cnt_q[sel] <= cnt_q[sel] + CW'(1);
                    off_q[sel] <= off_q[sel] + OFFW'(4);
                end
            end
        end
    end

    assign done_o = done_q;

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Table-driven scoreboard bench for vcve2_vrf_agu (VLEN=128, BASE_ADDR=0).
module tb_vcve2_vrf_agu;

    localparam logic [31:0] VRF_MASK = 32'h0000_01FF;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        load_i = 1'b0;
    logic [4:0]  vs1_i = '0, vs2_i = '0, vd_i = '0;
    logic [2:0]  lmul_i = '0;
    logic        get_rs1_i = 1'b0, get_rs2_i = 1'b0, get_rd_i = 1'b0;
    logic        ready_o, addr_valid_o, last_o, done_o, err_o;
    logic [31:0] addr_o;

    always #5 clk = ~clk;

    vcve2_vrf_agu #(.VLEN(128), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .load_i(load_i),
        .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i), .lmul_i(lmul_i),
        .get_rs1_i(get_rs1_i), .get_rs2_i(get_rs2_i), .get_rd_i(get_rd_i),
        .ready_o(ready_o), .addr_o(addr_o), .addr_valid_o(addr_valid_o),
        .last_o(last_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        last;
    } exp_t;

    typedef struct {
        logic [2:0]  lmul;
        logic [4:0]  vs1, vs2, vd;
        int unsigned op;
        logic [31:0] first;
        int unsigned n;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int unsigned n_applied = 0;
    int unsigned n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_applied++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic r1, input logic r2, input logic rd);
        @(negedge clk);
        load_i    = 1'b0;
        get_rs1_i = r1;
        get_rs2_i = r2;
        get_rd_i  = rd;
        #1;
    endtask

    task automatic serve_g(input logic r1, input logic r2, input logic rd,
                           input logic [31:0] a, input logic l);
        exp_t e;
        sb.push_back('{addr: a, last: l});
        cyc(r1, r2, rd);
        e = sb.pop_front();
        check("addr_valid", 32'(addr_valid_o), 32'd1);
        check("addr", addr_o, e.addr);
        check("last", 32'(last_o), 32'(e.last));
    endtask

    task automatic serve(input int unsigned op, input logic [31:0] a, input logic l);
        serve_g(op == 0, op == 1, op == 2, a, l);
    endtask

    task automatic load(input logic [2:0] lm, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic expect_err);
        @(negedge clk);
        load_i = 1'b1; lmul_i = lm; vs1_i = a; vs2_i = b; vd_i = d;
        get_rs1_i = 1'b0; get_rs2_i = 1'b0; get_rd_i = 1'b0;
        #1;
        // A get issued while not READY must be ignored and must not advance rs1.
        cyc(1'b1, 1'b0, 1'b0);
        check("init_valid", 32'(addr_valid_o), 32'd0);
        check("init_ready", 32'(ready_o), 32'd0);
        check("err", 32'(err_o), 32'(expect_err));
        cyc(1'b0, 1'b0, 1'b0);
        check("ready_after_load", 32'(ready_o), 32'(!expect_err));
        check("err_clear", 32'(err_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(ready_o), 32'd0);
        check({tag, "_addr"}, addr_o, 32'd0);
        check({tag, "_valid"}, 32'(addr_valid_o), 32'd0);
        check({tag, "_last"}, 32'(last_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'b000, 5'd2,  5'd3,  5'd4,  0, 32'h020, 4};
        vecs[1] = '{3'b000, 5'd2,  5'd3,  5'd4,  2, 32'h040, 4};
        vecs[2] = '{3'b011, 5'd24, 5'd0,  5'd8,  0, 32'h180, 32};
        vecs[3] = '{3'b111, 5'd5,  5'd6,  5'd7,  1, 32'h060, 2};
        vecs[4] = '{3'b101, 5'd1,  5'd2,  5'd7,  2, 32'h070, 1};
        vecs[5] = '{3'b100, 5'd10, 5'd11, 5'd12, 1, 32'h0B0, 4};
        vecs[6] = '{3'b010, 5'd8,  5'd12, 5'd16, 0, 32'h080, 16};
        vecs[7] = '{3'b110, 5'd9,  5'd1,  5'd3,  1, 32'h010, 1};

        #2 rst_ni = 1'b0;
        get_rd_i = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        get_rd_i = 1'b0;

        foreach (vecs[i]) begin
            load(vecs[i].lmul, vecs[i].vs1, vecs[i].vs2, vecs[i].vd, 1'b0);
            for (int unsigned j = 0; j < vecs[i].n; j++)
                serve(vecs[i].op, (vecs[i].first + 4 * j) & VRF_MASK, j == vecs[i].n - 1);
            if (vecs[i].op == 2) begin
                cyc(1'b0, 1'b0, 1'b0);
                check("done_pulse", 32'(done_o), 32'd1);
                check("ready_after_done", 32'(ready_o), 32'd0);
                cyc(1'b0, 1'b0, 1'b1);
                check("done_cleared", 32'(done_o), 32'd0);
                check("get_in_idle", 32'(addr_valid_o), 32'd0);
            end else begin
                serve(vecs[i].op, vecs[i].first, vecs[i].n == 1);
            end
        end

        // All three gets at once: rs1 wins, the others keep their first word.
        load(3'b000, 5'd2, 5'd3, 5'd4, 1'b0);
        serve_g(1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
        serve_g(1'b0, 1'b1, 1'b1, 32'h30, 1'b0);
        serve(2, 32'h40, 1'b0);
        serve(0, 32'h24, 1'b0);

`ifdef VCVE2_AGU_GROUP_CHECK_EN
        load(3'b001, 5'd0, 5'd2, 5'd3, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("err_ready", 32'(ready_o), 32'd0);
        check("err_one_cycle", 32'(err_o), 32'd0);
        check("err_get_valid", 32'(addr_valid_o), 32'd0);
`else
        load(3'b001, 5'd0, 5'd2, 5'd3, 1'b0);
        serve(2, 32'h30, 1'b0);
        load(3'b001, 5'd31, 5'd0, 5'd0, 1'b0);
        for (int unsigned j = 0; j < 8; j++)
            serve(0, (32'h1F0 + 4 * j) & VRF_MASK, j == 7);
        serve(0, 32'h1F0, 1'b0);
`endif

        // Reset mid-sequence, then load in the first cycle after release.
        load(3'b000, 5'd2, 5'd3, 5'd4, 1'b0);
        serve(2, 32'h40, 1'b0);
        serve(2, 32'h44, 1'b0);
        @(negedge clk);
        rst_ni = 1'b0;
        get_rd_i = 1'b1;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_ni = 1'b1;
        load_i = 1'b1; lmul_i = 3'b000; vs1_i = 5'd2; vs2_i = 5'd3; vd_i = 5'd4;
        get_rs1_i = 1'b0; get_rs2_i = 1'b0; get_rd_i = 1'b0;
        #1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("ready_after_reset_load", 32'(ready_o), 32'd1);
        serve(2, 32'h40, 1'b0);
        serve(2, 32'h44, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/vcve2_vrf_agu.md
VCVE2_VRF_AGU -- requirements
Module: vcve2_vrf_agu

Interface
REQ-001 SHALL have parameter VLEN, default 128, meaning vector register length in bits (power of two, >= 32).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of v0 word 0 in VRF memory (word aligned).
REQ-003 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-004 SHALL have port load_i in 1: capture a new operand set.
REQ-005 SHALL have ports vs1_i, vs2_i, vd_i in 5 each: vector register indices.
REQ-006 SHALL have port lmul_i in 3 (vcve2_pkg::vlmul_e): 000=1, 001=2, 010=4, 011=8, 101=F8, 110=F4, 111=F2, 100 reserved.
REQ-007 SHALL have ports get_rs1_i, get_rs2_i, get_rd_i in 1 each: request the next word address of that operand.
REQ-008 SHALL have port ready_o out 1: address generation ready to serve get requests.
REQ-009 SHALL have port addr_o out 32: byte address of the served word.
REQ-010 SHALL have port addr_valid_o out 1: addr_o is valid this cycle.
REQ-011 SHALL have port last_o out 1: served word is the final word of its operand group.
REQ-012 SHALL have port done_o out 1: one-cycle pulse after the final vd word is served.
REQ-013 SHALL have port err_o out 1: illegal register grouping (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE -> INIT -> READY -> IDLE.
REQ-015 SHALL, in any state, on load_i=1, capture vs1_i/vs2_i/vd_i/lmul_i, clear all word counters, and enter INIT next cycle; an in-flight sequence is aborted.
REQ-016 SHALL compute words-per-register WPR = VLEN/32 and group length N = WPR<<k for LMUL 2^k, WPR>>k for F2^k, minimum 1; reserved encoding treated as LMUL 1.
REQ-017 SHALL, in INIT, load per-operand address registers with BASE_ADDR + idx*(VLEN/8) and enter READY next cycle.
REQ-018 SHALL drive ready_o=1 only in READY.
REQ-019 SHALL serve at most one get per cycle, priority rs1 > rs2 > rd; unserved gets are dropped, and gets outside READY are ignored.
REQ-020 SHALL, on a served get, drive addr_o = that operand's current address and addr_valid_o=1 combinationally in the same cycle, then advance that address by 4 and increment its counter at the next clock edge.
REQ-021 SHALL wrap an operand address from BASE_ADDR+32*VLEN/8-4 to BASE_ADDR (register index wraps mod 32).
REQ-022 SHALL assert last_o with a served get when that operand's counter equals N-1; further gets of that operand wrap to its first word.
REQ-023 SHALL, on the served rd get with last_o=1, pulse done_o for one cycle and return to IDLE.
REQ-024 SHALL drive addr_o=0 when addr_valid_o=0.

Reset
REQ-025 SHALL, on rst_ni=0, asynchronously enter IDLE and clear all counters, addresses and captured fields.
REQ-026 SHALL drive ready_o, addr_valid_o, last_o, done_o, err_o = 0 and addr_o = 0 while in reset.
REQ-027 SHALL accept load_i in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL honour macro VCVE2_AGU_GROUP_CHECK_EN.
REQ-029 SHALL, with the macro defined and LMUL > 1, on load_i with any index not a multiple of LMUL, assert err_o for one cycle and stay in or return to IDLE.
REQ-030 SHALL, without the macro, tie err_o to 0 and accept all indices, using the wrap rule of REQ-021.

Verification
REQ-031 SHALL cover: VLEN=128, BASE=0, load vs1=2, vs2=3, vd=4, LMUL=1, then rs1 x4 -> addr 0x20, 0x24, 0x28, 0x2C, last_o on 0x2C.
REQ-032 SHALL cover: same setup, rd x4 -> addr 0x40..0x4C, done_o pulse one cycle after 0x4C, ready_o=0 afterwards.
REQ-033 SHALL cover: LMUL=8, vs1=24, checker off -> 32 rs1 gets end at 0x1FC, last_o on 0x1FC.
REQ-034 SHALL cover: get_rs1_i=get_rs2_i=get_rd_i=1 in READY -> only rs1 served, rs2/rd counters unchanged.
REQ-035 SHALL cover: checker on, LMUL=2, vd=3 -> err_o=1 for one cycle, ready_o stays 0.
REQ-036 SHALL cover: rst_ni low mid-sequence after 2 rd gets -> all outputs 0; after new load vd=4, first rd addr = 0x40.
